// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: parser states, header byte and opcode constants for uart_cmd_ctrl.
package uart_cmd_pkg;
    typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD, GOT_DATA} state_t;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [3:0] OP_DIGIT = 4'h1;
    localparam logic [3:0] OP_BLANK = 4'h2;
    localparam logic [3:0] OP_CLEAR = 4'h3;
endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte down-counter, reloads on load, saturates at zero.
module uart_cmd_timeout #(
    parameter int TICKS = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);
    localparam int W = $clog2(TICKS + 1);
    logic [W-1:0] count;
    assign expired = count == '0;
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (load) count <= W'(TICKS);
        else if (!expired) count <= count - 1'b1;
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: 4-byte UART command parser driving digit/blank registers.
// Define UART_CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_TICKS idle cycles.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy
);
    state_t state, state_nx;
    logic [7:0] cmd, data;
    logic chk_stage, good, timeout;
    assign busy = state != IDLE;
    assign chk_stage = rx_valid && state == GOT_DATA;
    assign good = rx_byte == (cmd ^ data) &&
                  (cmd[7:4] == OP_DIGIT || cmd[7:4] == OP_BLANK || cmd[7:4] == OP_CLEAR);
`ifdef UART_CMD_TIMEOUT_EN
    logic expired;
    uart_cmd_timeout #(.TICKS(TIMEOUT_TICKS)) u_timeout (
        .clk(clk),
        .rst(rst),
        .load(rx_valid && (busy || rx_byte == HDR_BYTE)),
        .expired(expired)
    );
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = expired && busy && !rx_valid;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        if (timeout) state_nx = IDLE;
        else if (rx_valid) begin
            case (state)
                IDLE:    state_nx = rx_byte == HDR_BYTE ? GOT_HDR : IDLE;
                GOT_HDR: state_nx = GOT_CMD;
                GOT_CMD: state_nx = GOT_DATA;
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= '0;
            data      <= '0;
            digits    <= '0;
            blank     <= 4'hF;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_ok  <= chk_stage && good;
            frame_err <= (chk_stage && !good) || timeout;
            if (rx_valid && state == GOT_HDR) cmd <= rx_byte;
            if (rx_valid && state == GOT_CMD) data <= rx_byte;
            if (chk_stage && good) begin
                if (cmd[7:4] == OP_DIGIT) digits[{cmd[1:0], 2'b00} +: 4] <= data[3:0];
                if (cmd[7:4] == OP_BLANK) blank <= data[3:0];
                if (cmd[7:4] == OP_CLEAR) begin
                    digits <= '0;
                    blank  <= 4'hF;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl (UART_CMD_TIMEOUT_EN optional).
module tb_uart_cmd_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        frame_ok, frame_err, busy;
    int total = 0;
    int bad = 0;
    int errs;

    uart_cmd_ctrl #(.TIMEOUT_TICKS(20)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .digits(digits), .blank(blank), .frame_ok(frame_ok),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_digits", 32'(digits), 32'h0000);
        chk("rst_blank", 32'(blank), 32'hF);
        chk("rst_ok", 32'(frame_ok), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_busy", 32'(busy), 0);

        send(8'hA5);
        chk("hdr_busy", 32'(busy), 1);
        send(8'h11); send(8'h07); send(8'h16);
        chk("d1_ok", 32'(frame_ok), 1);
        chk("d1_err", 32'(frame_err), 0);
        chk("d1_digits", 32'(digits), 32'h0070);
        chk("d1_busy", 32'(busy), 0);
        tick();
        chk("d1_ok_pulse", 32'(frame_ok), 0);

        send(8'hA5); send(8'h20); send(8'h05); send(8'h25);
        chk("blank_ok", 32'(frame_ok), 1);
        chk("blank_val", 32'(blank), 32'h5);

        send(8'hA5); send(8'h13); send(8'h09); send(8'h00);
        chk("badchk_err", 32'(frame_err), 1);
        chk("badchk_ok", 32'(frame_ok), 0);
        chk("badchk_digits", 32'(digits), 32'h0070);
        chk("badchk_blank", 32'(blank), 32'h5);
        tick();
        chk("badchk_err_pulse", 32'(frame_err), 0);

        send(8'hA5); send(8'h40); send(8'h01); send(8'h41);
        chk("badop_err", 32'(frame_err), 1);
        chk("badop_digits", 32'(digits), 32'h0070);

        send(8'hA5); send(8'h10); send(8'hA5); send(8'hB5);
        chk("a5_payload_ok", 32'(frame_ok), 1);
        chk("a5_payload_digits", 32'(digits), 32'h0075);

        send(8'h00);
        chk("junk_busy", 32'(busy), 0);
        send(8'hFF); send(8'hA5); send(8'h30); send(8'h00); send(8'h30);
        chk("clr_ok", 32'(frame_ok), 1);
        chk("clr_digits", 32'(digits), 32'h0000);
        chk("clr_blank", 32'(blank), 32'hF);

        send(8'hA5); send(8'h11);
        rst = 1'b1;
        rx_byte = 8'h07;
        rx_valid = 1'b1;
        tick();
        rst = 1'b0;
        rx_valid = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(frame_err), 0);
        tick();
        chk("midrst_err2", 32'(frame_err), 0);
        send(8'hA5); send(8'h12); send(8'h03); send(8'h11);
        chk("post_rst_ok", 32'(frame_ok), 1);
        chk("post_rst_digits", 32'(digits), 32'h0300);

        send(8'hA5); send(8'h1F); send(8'h09); send(8'h16);
        chk("idx3_digits", 32'(digits), 32'h9300);
        repeat (5) tick();
        chk("hold_digits", 32'(digits), 32'h9300);
        chk("hold_blank", 32'(blank), 32'hF);
        chk("hold_ok", 32'(frame_ok), 0);

        send(8'hA5); send(8'h11);
        errs = 0;
        for (int i = 0; i < 25; i++) begin
            if (frame_err) errs++;
            tick();
        end
`ifdef UART_CMD_TIMEOUT_EN
        chk("to_err_count", 32'(errs), 1);
        chk("to_busy", 32'(busy), 0);
        send(8'hA5); send(8'h11); send(8'h02); send(8'h13);
        chk("to_next_ok", 32'(frame_ok), 1);
        chk("to_next_digits", 32'(digits), 32'h9320);
`else
        chk("noto_err_count", 32'(errs), 0);
        chk("noto_busy", 32'(busy), 1);
        send(8'h02); send(8'h13);
        chk("noto_late_ok", 32'(frame_ok), 1);
        chk("noto_late_digits", 32'(digits), 32'h9320);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
